// File: rtl/motor_axil_cfg_seq.sv
// AXI4-Lite master that writes a table of words to the motor register file,
// reads each one back and compares it, reporting done or a coded failure.
module motor_axil_cfg_seq #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_ENTRIES = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    TIMEOUT     = 255
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic                      start,
   input  logic [NUM_ENTRIES*32-1:0] cfg_data,
   output logic                      busy,
   output logic                      done,
   output logic                      fail,
   output logic [2:0]                err_code,
   output logic [3:0]                err_index,
   output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                M_AXI_AWPROT,
   output logic                      M_AXI_AWVALID,
   input  logic                      M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                      M_AXI_WVALID,
   input  logic                      M_AXI_WREADY,
   input  logic [1:0]                M_AXI_BRESP,
   input  logic                      M_AXI_BVALID,
   output logic                      M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                M_AXI_ARPROT,
   output logic                      M_AXI_ARVALID,
   input  logic                      M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                M_AXI_RRESP,
   input  logic                      M_AXI_RVALID,
   output logic                      M_AXI_RREADY
);

   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WB, S_RA, S_RD, S_CHK, S_DONE, S_FAIL
   } state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [3:0]            idx;
   logic                  aw_done, w_done;
   logic [DATA_WIDTH-1:0] rd_q;
   logic [2:0]            code_nxt;
   logic                  tmo, aw_hs, w_hs, start_ok, waiting;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           exp_word;

   assign addr     = BASE_ADDR + ADDR_WIDTH'({idx, 2'b00});
   assign exp_word = cfg_data[32*idx +: 32];
   assign tmo      = (cnt == CW'(TIMEOUT));
   assign waiting  = (state == S_WR) || (state == S_WB) || (state == S_RA) || (state == S_RD);
   assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));

   // Handshake outputs drop in the very cycle the timeout is reached.
   assign M_AXI_AWVALID = (state == S_WR) && !aw_done && !tmo;
   assign M_AXI_WVALID  = (state == S_WR) && !w_done && !tmo;
   assign M_AXI_BREADY  = (state == S_WB) && !tmo;
   assign M_AXI_ARVALID = (state == S_RA) && !tmo;
   assign M_AXI_RREADY  = (state == S_RD) && !tmo;
   assign M_AXI_AWADDR  = (state == S_WR) ? addr : '0;
   assign M_AXI_WDATA   = (state == S_WR) ? DATA_WIDTH'(exp_word) : '0;
   assign M_AXI_ARADDR  = (state == S_RA) ? addr : '0;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WSTRB   = '1;
   assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;

   assign busy = waiting || (state == S_CHK);
   assign done = (state == S_DONE);
   assign fail = (state == S_FAIL);

   always_comb begin
      state_nxt = state;
      code_nxt  = 3'd0;
      case (state)
         S_IDLE, S_DONE, S_FAIL: if (start_ok) state_nxt = S_WR;
         S_WR: begin
            if (tmo) begin
               state_nxt = S_FAIL; code_nxt = 3'd4;
            end else if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WB;
         end
         S_WB: begin
            if (tmo) begin
               state_nxt = S_FAIL; code_nxt = 3'd4;
            end else if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  state_nxt = S_FAIL; code_nxt = 3'd1;
               end else state_nxt = S_RA;
            end
         end
         S_RA: begin
            if (tmo) begin
               state_nxt = S_FAIL; code_nxt = 3'd4;
            end else if (M_AXI_ARREADY) state_nxt = S_RD;
         end
         S_RD: begin
            if (tmo) begin
               state_nxt = S_FAIL; code_nxt = 3'd4;
            end else if (M_AXI_RVALID) begin
               if (M_AXI_RRESP != 2'b00) begin
                  state_nxt = S_FAIL; code_nxt = 3'd2;
               end else state_nxt = S_CHK;
            end
         end
         S_CHK: begin
            if (rd_q != DATA_WIDTH'(exp_word)) begin
               state_nxt = S_FAIL; code_nxt = 3'd3;
            end else if (idx == 4'(NUM_ENTRIES - 1)) state_nxt = S_DONE;
            else state_nxt = S_WR;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idx       <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rd_q      <= '0;
         err_code  <= '0;
         err_index <= '0;
      end else begin
         state <= state_nxt;
         // Counter restarts on every state entry, so each handshake gets its own budget.
         if (state_nxt != state) cnt <= '0;
         else if (waiting)       cnt <= cnt + 1'b1;
         aw_done <= (state == S_WR) && (state_nxt == S_WR) && (aw_done || aw_hs);
         w_done  <= (state == S_WR) && (state_nxt == S_WR) && (w_done || w_hs);
         if (M_AXI_RVALID && M_AXI_RREADY) rd_q <= M_AXI_RDATA;
         if (start_ok) begin
            idx      <= '0;
            err_code <= '0;
         end
         if ((state == S_CHK) && (state_nxt == S_WR)) idx <= idx + 1'b1;
         if ((state_nxt == S_FAIL) && (state != S_FAIL)) begin
            err_code  <= code_nxt;
            err_index <= idx;
         end
      end
   end

endmodule

// File: tb/tb_motor_axil_cfg_seq.sv
// Directed bench: behavioural AXI4-Lite slave with fault knobs, table of
// scenarios plus hand sequences for timeout restart and mid-sequence reset.
module tb_motor_axil_cfg_seq;

   logic tb_ACLK = 1'b0;
   always #5 tb_ACLK = ~tb_ACLK;

   logic         ARESETN, start;
   logic [127:0] cfg_data;
   logic         busy, done, fail;
   logic [2:0]   err_code;
   logic [3:0]   err_index;
   logic [31:0]  awaddr, wdata, araddr, rdata;
   logic [2:0]   awprot, arprot;
   logic [3:0]   wstrb;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [1:0]   bresp, rresp;

   motor_axil_cfg_seq #(.NUM_ENTRIES(4), .TIMEOUT(16)) dut (
      .ACLK(tb_ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
      .busy(busy), .done(done), .fail(fail), .err_code(err_code), .err_index(err_index),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   // ---------------- slave model ----------------
   int          aw_delay, bresp_idx, corrupt_idx;
   logic        ar_block;
   logic [31:0] mem [16];
   logic        got_aw, got_w;
   logic [3:0]  wa_q, wa_eff;
   logic [31:0] wd_q, wd_eff;
   int          aw_wait;

   assign awready = awvalid && (aw_wait >= aw_delay);
   assign wready  = 1'b1;
   assign arready = !ar_block;
   assign wa_eff  = got_aw ? wa_q : awaddr[5:2];
   assign wd_eff  = got_w ? wd_q : wdata;

   always @(posedge tb_ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         got_aw <= 1'b0; got_w <= 1'b0; aw_wait <= 0;
         bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
         wa_q <= '0; wd_q <= '0;
      end else begin
         if (awvalid && awready) aw_wait <= 0;
         else if (awvalid)       aw_wait <= aw_wait + 1;
         if (awvalid && awready) begin got_aw <= 1'b1; wa_q <= awaddr[5:2]; end
         if (wvalid && wready)   begin got_w <= 1'b1; wd_q <= wdata; end
         if (bvalid && bready) bvalid <= 1'b0;
         if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) && !bvalid) begin
            mem[wa_eff] <= wd_eff;
            bvalid <= 1'b1;
            bresp  <= (int'(wa_eff) == bresp_idx) ? 2'b10 : 2'b00;
            got_aw <= 1'b0; got_w <= 1'b0;
         end
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= (int'(araddr[5:2]) == corrupt_idx) ? (mem[araddr[5:2]] ^ 32'h1) : mem[araddr[5:2]];
         end
      end
   end

   // ---------------- channel monitor ----------------
   logic clr;
   int   n_aw, n_w, n_ar, n_awv, n_wv, n_arv;
   always @(posedge tb_ACLK) begin
      if (clr) begin
         n_aw <= 0; n_w <= 0; n_ar <= 0; n_awv <= 0; n_wv <= 0; n_arv <= 0;
      end else begin
         if (awvalid) n_awv <= n_awv + 1;
         if (wvalid)  n_wv  <= n_wv + 1;
         if (arvalid) n_arv <= n_arv + 1;
         if (awvalid && awready) n_aw <= n_aw + 1;
         if (wvalid && wready)   n_w  <= n_w + 1;
         if (arvalid && arready) n_ar <= n_ar + 1;
      end
   end

   // ---------------- checking ----------------
   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Pulses start and returns cycles from busy rising to done/fail.
   task automatic run_seq(output int n);
      @(negedge tb_ACLK); clr = 1'b1;
      @(negedge tb_ACLK); clr = 1'b0; start = 1'b1;
      @(negedge tb_ACLK); start = 1'b0;
      chk("busy_rise", busy, 1'b1);
      n = 0;
      while (!(done || fail) && n < 500) begin
         @(negedge tb_ACLK); n++;
      end
      if (n >= 500) begin
         bad++; total++;
         $display("FAIL wait_end: got no done/fail want end within 500 cycles");
      end
   endtask

   typedef struct {
      int         aw_delay, bresp_idx, corrupt_idx;
      logic       ar_block;
      logic       exp_done, exp_fail;
      logic [2:0] exp_code;
      logic [3:0] exp_idx;
      int         exp_cycles, exp_aw, exp_w, exp_ar, exp_awv, exp_wv, exp_arv;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int n;
      vecs[0] = '{0, -1, -1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 20, 4, 4, 4,  4, 4,  4};
      vecs[1] = '{3, -1, -1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 32, 4, 4, 4, 16, 4,  4};
      vecs[2] = '{0,  2, -1, 1'b0, 1'b0, 1'b1, 3'd1, 4'd2, 12, 3, 3, 2,  3, 3,  2};
      vecs[3] = '{0, -1,  1, 1'b0, 1'b0, 1'b1, 3'd3, 4'd1, 10, 2, 2, 2,  2, 2,  2};
      vecs[4] = '{0, -1, -1, 1'b1, 1'b0, 1'b1, 3'd4, 4'd0, 19, 1, 1, 0,  1, 1, 16};

      cfg_data = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101ffff};
      aw_delay = 0; bresp_idx = -1; corrupt_idx = -1; ar_block = 1'b0;
      start = 1'b0; clr = 1'b1; ARESETN = 1'b0;
      repeat (3) @(negedge tb_ACLK);
      chk("rst_flags", {busy, done, fail, err_code, err_index}, '0);
      chk("rst_valid", {awvalid, wvalid, bready, arvalid, rready}, '0);
      chk("rst_addr", {awaddr, araddr}, '0);
      chk("rst_wdata", wdata, '0);
      ARESETN = 1'b1;
      @(negedge tb_ACLK);
      chk("idle_flags", {busy, done, fail}, '0);

      for (int v = 0; v < 5; v++) begin
         aw_delay = vecs[v].aw_delay; bresp_idx = vecs[v].bresp_idx;
         corrupt_idx = vecs[v].corrupt_idx; ar_block = vecs[v].ar_block;
         run_seq(n);
         $display("vector %0d ended after %0d cycles", v, n);
         chk("done", done, vecs[v].exp_done);
         chk("fail", fail, vecs[v].exp_fail);
         chk("err_code", err_code, vecs[v].exp_code);
         if (vecs[v].exp_fail) chk("err_index", err_index, vecs[v].exp_idx);
         chk("cycles", n, vecs[v].exp_cycles);
         chk("busy_end", busy, 1'b0);
         chk("valid_end", {awvalid, wvalid, arvalid, bready, rready}, '0);
         chk("aw_count", n_aw, vecs[v].exp_aw);
         chk("w_count", n_w, vecs[v].exp_w);
         chk("ar_count", n_ar, vecs[v].exp_ar);
         chk("awvalid_cycles", n_awv, vecs[v].exp_awv);
         chk("wvalid_cycles", n_wv, vecs[v].exp_wv);
         chk("arvalid_cycles", n_arv, vecs[v].exp_arv);
         if (v == 0) begin
            chk("mem0", mem[0], 32'h0101ffff);
            chk("mem1", mem[1], 32'habcd0001);
            chk("mem2", mem[2], 32'hdead0011);
            chk("mem3", mem[3], 32'hbeef0011);
         end
      end

      // Restart after the timeout failure: flags clear and a full pass completes.
      ar_block = 1'b0;
      @(negedge tb_ACLK); start = 1'b1;
      @(negedge tb_ACLK); start = 1'b0;
      chk("restart_fail_clr", fail, 1'b0);
      chk("restart_code_clr", err_code, 3'd0);
      n = 0;
      while (!(done || fail) && n < 500) begin
         @(negedge tb_ACLK); n++;
      end
      chk("restart_done", {done, fail}, 2'b10);
      chk("restart_cycles", n, 20);

      // start while busy is ignored: pulse it mid-sequence, run length unchanged.
      @(negedge tb_ACLK); start = 1'b1;
      @(negedge tb_ACLK); start = 1'b0;
      repeat (7) @(negedge tb_ACLK);
      start = 1'b1;
      @(negedge tb_ACLK); start = 1'b0;
      n = 8;
      while (!(done || fail) && n < 500) begin
         @(negedge tb_ACLK); n++;
      end
      chk("busy_start_ignored", n, 20);

      // Asynchronous reset while waiting for entry 1's write response.
      @(negedge tb_ACLK); clr = 1'b1;
      @(negedge tb_ACLK); clr = 1'b0; start = 1'b1;
      @(negedge tb_ACLK); start = 1'b0;
      n = 0;
      while (!(bready && n_aw == 2) && n < 100) begin
         @(negedge tb_ACLK); n++;
      end
      chk("reach_wb1", {bready, n_aw == 2}, 2'b11);
      #2 ARESETN = 1'b0;
      #1;
      chk("async_rst_flags", {busy, done, fail, err_code, err_index}, '0);
      chk("async_rst_valid", {awvalid, wvalid, bready, arvalid, rready}, '0);
      @(negedge tb_ACLK); ARESETN = 1'b1;
      run_seq(n);
      chk("post_rst_done", {done, fail}, 2'b10);
      chk("post_rst_cycles", n, 20);
      chk("post_rst_aw", n_aw, 4);
      chk("post_rst_mem0", mem[0], 32'h0101ffff);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/motor_axil_cfg_seq.md
# motor_axil_cfg_seq

Hardware configuration sequencer that drives the motor IP's AXI4-Lite slave port as a master. On a start pulse it writes a table of NUM_ENTRIES 32-bit words to consecutive registers from BASE_ADDR, reads each one back, and compares it against the written value. It replaces software or BFM bring-up of the motor register file and sits between the boot/control logic and the motor AXI4-Lite slave.

## Interface
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: AXI data width (fixed 32; WSTRB 4 bits).
- NUM_ENTRIES, 4: number of registers written and verified (1..16).
- BASE_ADDR, 32'h0000_0000: address of entry 0; entry i at BASE_ADDR + 4*i.
- TIMEOUT, 255: max cycles waited for any single handshake before failing.

- ACLK  in  1  clock.
- ARESETN  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE, DONE, or FAIL.
- cfg_data  in  NUM_ENTRIES*32  entry i at bits [32*i+31:32*i]; must be held stable while busy.
- busy  out  1  high from the cycle after an accepted start until DONE/FAIL.
- done  out  1  level; all entries verified OK; cleared by the next accepted start.
- fail  out  1  level; sequence aborted; cleared by the next accepted start.
- err_code  out  3  0 none, 1 BRESP!=OKAY, 2 RRESP!=OKAY, 3 readback mismatch, 4 timeout.
- err_index  out  4  entry index at failure.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY; WDATA/WSTRB/WVALID/WREADY; BRESP/BVALID/BREADY; ARADDR/ARPROT/ARVALID/ARREADY; RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels. AWPROT = ARPROT = 3'b000. WSTRB = 4'hF.

## Operation
- States: IDLE, WR (AW+W), WB (write response), RA (read address), RD (read data), CHK, DONE, FAIL.
- IDLE/DONE/FAIL + start: idx<=0, done/fail<=0, err_code<=0 -> WR.
- WR: AWVALID and WVALID are asserted together. Each channel drops independently on its own VALID&READY and stays low afterwards. When both have completed -> WB.
- WB: BREADY=1. On BVALID: if BRESP!=2'b00, go to FAIL with code 1; otherwise go to RA.
- RA: ARVALID=1 with ARADDR = write address; on ARREADY -> RD.
- RD: RREADY=1. On RVALID: capture RDATA. If RRESP!=2'b00, go to FAIL with code 2; otherwise go to CHK.
- CHK (one cycle): if captured != cfg_data[idx], go to FAIL with code 3. Otherwise, if idx==NUM_ENTRIES-1, go to DONE; else idx++ and go to WR.
- Address: BASE_ADDR + {idx,2'b00}, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
- Timeout: an 8+ bit counter clears on every state entry and increments each cycle in WR/WB/RA/RD. Reaching TIMEOUT goes to FAIL with code 4, and all VALID/READY outputs drop the same cycle.
- FAIL latches err_index=idx. err_code holds until the next start.
- start while busy is ignored. start in the same cycle as a handshake has no effect on that handshake.

## Timing
- Reset (async assert, sync deassert by system): state IDLE; all VALID/READY outputs 0; busy, done, fail 0; err_code 0; err_index 0; addresses/data 0. Reset mid-transaction drops all VALIDs immediately; no completion is required.
- start at cycle T -> busy=1 and AWVALID=WVALID=1 at T+1.
- With zero-wait slave (READY always 1, responses next cycle): per entry WR 1, WB 1, RA 1, RD 1, CHK 1 = 5 cycles. Total NUM_ENTRIES*5. done rises on the cycle after the last CHK.
- VALID is never deasserted before its handshake (AXI rule), except on timeout.
- BREADY/RREADY are high only in WB/RD. Responses arriving outside those states are not accepted.

## Test plan
- Zero-wait slave, BASE_ADDR 0, data {0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011} -> writes at 0x0,0x4,0x8,0xC; readbacks match; done=1 exactly 20 cycles after busy rises; fail=0.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles; one AW and one W per entry; done=1.
- Slave returns BRESP=2'b10 on entry 2 -> fail=1, err_code=1, err_index=2; no AR issued for entry 2.
- Slave corrupts the readback of entry 1 to 0xabcd0000 -> fail=1, err_code=3, err_index=1; entries 2-3 never written.
- ARREADY held low, TIMEOUT=16 -> fail=1 and err_code=4 at 16 cycles in RA; ARVALID=0 after. A new start then clears fail and a full sequence completes.
- ARESETN pulsed low during WB of entry 1 -> all outputs at reset values asynchronously. After release, start re-runs from entry 0.
